sram1d_fifo_ctrl: RTL and testbench



---
 rtl/sram1d_fifo_ctrl_pkg.sv | 26 ++
 rtl/SRAM1D_WRAP.sv | 47 ++++
 rtl/sram1d_fifo_ctrl_out_buf2.sv | 87 ++++++++
 rtl/sram1d_fifo_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram1d_fifo_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sram1d_fifo_ctrl_pkg.sv
// Shared types and helpers for the SRAM-backed FIFO controller.
//   sram_op_e      : the single SRAM port's operation in a given cycle
//   sram_op_select : turns the granted write and the read request into one port operation
package sram1d_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    SRAM_IDLE  = 2'b00,
    SRAM_WRITE = 2'b01,
    SRAM_READ  = 2'b10
  } sram_op_e;

  // A granted write has already beaten any read (InReady folds in the
  // priority bit), so a write request always owns the port.
  function automatic sram_op_e sram_op_select(input logic write_grant, input logic read_want);
    sram_op_e op;
    if (write_grant) begin
      op = SRAM_WRITE;
    end else if (read_want) begin
      op = SRAM_READ;
    end else begin
      op = SRAM_IDLE;
    end
    return op;
  endfunction

endpackage

// File: rtl/SRAM1D_WRAP.sv
// Single-port synchronous SRAM wrapper (behavioural storage).
//   Clock   : clock
//   Reset   : synchronous active-high reset, clears the read register only
//   Enable  : access strobe
//   Write   : 1 = write DIn to Address, 0 = read Address
//   Address : word address
//   DIn     : write data
//   DOut    : read data, valid the cycle after a read access
module SRAM1D_WRAP #(
  parameter int DWidth = 64,
  parameter int AWidth = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Write,
  input  logic [AWidth-1:0] Address,
  input  logic [DWidth-1:0] DIn,
  output logic [DWidth-1:0] DOut
);

  logic [DWidth-1:0] mem_r [(1 << AWidth)];
  logic [DWidth-1:0] dout_r;

  // Storage array write port; contents are never reset.
  always_ff @(posedge Clock) begin
    if (Enable && Write) begin
      mem_r[Address] <= DIn;
    end else begin
      mem_r[Address] <= mem_r[Address];
    end
  end

  // Registered read port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dout_r <= '0;
    end else if (Enable && !Write) begin
      dout_r <= mem_r[Address];
    end else begin
      dout_r <= dout_r;
    end
  end

  assign DOut = dout_r;

endmodule

// File: rtl/sram1d_fifo_ctrl_out_buf2.sv
// Two-entry register FIFO used as the output stage of sram1d_fifo_ctrl.
//   clk       : clock
//   rst_n     : synchronous active-low reset (drops contents)
//   push      : write push_data at the tail
//   push_data : data to push
//   pop       : remove the head entry
//   data      : head entry (don't-care while occ==0)
//   occ       : occupancy 0..2
module fifo_out_buf2 #(
  parameter int DWidth = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWidth-1:0] push_data,
  input  logic              pop,
  output logic [DWidth-1:0] data,
  output logic [1:0]        occ
);

  logic [DWidth-1:0] slot0_r;
  logic [DWidth-1:0] slot1_r;
  logic [1:0]        occ_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  // Qualify requests so an illegal pop/push can never corrupt occupancy.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && (occ_r != 2'd0)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((occ_r != 2'd2) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Data slots: slot0 is always the head, slot1 the second entry.
  always_ff @(posedge clk) begin
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (occ_r == 2'd0) begin
          slot0_r <= push_data;
        end else begin
          slot1_r <= push_data;
        end
      end
      2'b01: begin
        slot0_r <= slot1_r;
      end
      2'b11: begin
        if (occ_r == 2'd1) begin
          slot0_r <= push_data;
        end else begin
          slot0_r <= slot1_r;
          slot1_r <= push_data;
        end
      end
      default: begin
        slot0_r <= slot0_r;
        slot1_r <= slot1_r;
      end
    endcase
  end

  assign data = slot0_r;
  assign occ  = occ_r;

endmodule

// File: rtl/sram1d_fifo_ctrl.sv
// Ready/valid FIFO backed by one single-port SRAM1D_WRAP plus a 2-entry
// output register buffer. Enqueue writes and dequeue reads share the SRAM
// port; an empty FIFO bypasses the SRAM entirely.
//   Clock    : clock, all state on rising edge
//   Reset_N  : synchronous active-low reset
//   InData   : enqueue data          InValid/InReady  : enqueue handshake
//   OutData  : head of FIFO          OutValid/OutReady: dequeue handshake
//   Count    : entries held (SRAM + in-flight read + output buffer)
module sram1d_fifo_ctrl
  import sram1d_fifo_ctrl_pkg::*;
#(
  parameter int DWidth = 64,
  parameter int AWidth = 7
) (
  input  logic              Clock,
  input  logic              Reset_N,
  input  logic [DWidth-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [DWidth-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [AWidth+1:0] Count
);

  localparam int CW = AWidth + 2;
  localparam logic [AWidth:0] MEM_FULL = (AWidth + 1)'(1 << AWidth);

  logic [AWidth-1:0] wr_ptr_r;
  logic [AWidth-1:0] rd_ptr_r;
  logic [AWidth:0]   mem_cnt_r;
  logic              in_flight_r;
  logic              prio_r;

  logic [1:0]        out_occ_s;
  logic [DWidth-1:0] out_data_s;
  logic [DWidth-1:0] sram_dout_s;

  logic              byp_s;
  logic              read_want_s;
  logic              write_ok_s;
  logic              in_ready_s;
  logic              enq_s;
  logic              conflict_s;
  sram_op_e          op_s;

  logic              sram_en_s;
  logic              sram_we_s;
  logic [AWidth-1:0] sram_addr_s;

  logic              buf_push_s;
  logic [DWidth-1:0] buf_push_data_s;
  logic              buf_pop_s;

  // Port arbitration from registered state. The read credit counts the
  // in-flight word but not a same-cycle dequeue, so OutBuf cannot overflow.
  always_comb begin
    byp_s       = (mem_cnt_r == '0) && !in_flight_r && (out_occ_s != 2'd2);
    read_want_s = (mem_cnt_r != '0) && ((out_occ_s + {1'b0, in_flight_r}) < 2'd2);
    write_ok_s  = !byp_s && (mem_cnt_r != MEM_FULL);
    in_ready_s  = byp_s || (write_ok_s && (!read_want_s || prio_r));
    enq_s       = InValid && in_ready_s;
    conflict_s  = read_want_s && InValid && write_ok_s;
    op_s        = sram_op_select(enq_s && !byp_s, read_want_s);
  end

  // SRAM port drive for the selected operation.
  always_comb begin
    sram_en_s   = 1'b0;
    sram_we_s   = 1'b0;
    sram_addr_s = wr_ptr_r;
    case (op_s)
      SRAM_WRITE: begin
        sram_en_s   = 1'b1;
        sram_we_s   = 1'b1;
        sram_addr_s = wr_ptr_r;
      end
      SRAM_READ: begin
        sram_en_s   = 1'b1;
        sram_we_s   = 1'b0;
        sram_addr_s = rd_ptr_r;
      end
      default: begin
        sram_en_s   = 1'b0;
        sram_we_s   = 1'b0;
        sram_addr_s = wr_ptr_r;
      end
    endcase
  end

  // Pointer, fill count, in-flight flag and write/read priority.
  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      mem_cnt_r   <= '0;
      in_flight_r <= 1'b0;
      prio_r      <= 1'b0;
    end else begin
      case (op_s)
        SRAM_WRITE: begin
          wr_ptr_r  <= wr_ptr_r + {{(AWidth-1){1'b0}}, 1'b1};
          mem_cnt_r <= mem_cnt_r + {{AWidth{1'b0}}, 1'b1};
        end
        SRAM_READ: begin
          rd_ptr_r  <= rd_ptr_r + {{(AWidth-1){1'b0}}, 1'b1};
          mem_cnt_r <= mem_cnt_r - {{AWidth{1'b0}}, 1'b1};
        end
        default: begin
          wr_ptr_r  <= wr_ptr_r;
          rd_ptr_r  <= rd_ptr_r;
          mem_cnt_r <= mem_cnt_r;
        end
      endcase
      in_flight_r <= (op_s == SRAM_READ);
      if (conflict_s) begin
        prio_r <= !prio_r;
      end else begin
        prio_r <= prio_r;
      end
    end
  end

  // Output buffer feed: a bypass and a read return can never coincide
  // because bypass requires no read in flight.
  always_comb begin
    buf_push_s      = in_flight_r || (enq_s && byp_s);
    buf_push_data_s = InData;
    if (in_flight_r) begin
      buf_push_data_s = sram_dout_s;
    end else begin
      buf_push_data_s = InData;
    end
    buf_pop_s = OutReady && (out_occ_s != 2'd0);
  end

  fifo_out_buf2 #(
    .DWidth(DWidth)
  ) u_out_buf (
    .clk       (Clock),
    .rst_n     (Reset_N),
    .push      (buf_push_s),
    .push_data (buf_push_data_s),
    .pop       (buf_pop_s),
    .data      (out_data_s),
    .occ       (out_occ_s)
  );

  SRAM1D_WRAP #(
    .DWidth(DWidth),
    .AWidth(AWidth)
  ) u_sram (
    .Clock   (Clock),
    .Reset   (~Reset_N),
    .Enable  (sram_en_s),
    .Write   (sram_we_s),
    .Address (sram_addr_s),
    .DIn     (InData),
    .DOut    (sram_dout_s)
  );

  assign InReady  = in_ready_s;
  assign OutValid = (out_occ_s != 2'd0);
  assign OutData  = out_data_s;
  assign Count    = CW'(mem_cnt_r) + CW'(in_flight_r) + CW'(out_occ_s);

endmodule

// File: tb/tb_sram1d_fifo_ctrl.sv
module tb_sram1d_fifo_ctrl;

  localparam int DW = 64;
  localparam int AW = 2;
  localparam int SRAM_WORDS = 4;

  logic          Clock = 1'b0;
  logic          Reset_N = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] OutData;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [AW+1:0] Count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents by location.
  logic [DW-1:0] m_out[$];
  logic [DW-1:0] m_mem[$];
  bit            m_infl = 1'b0;
  logic [DW-1:0] m_infl_d = '0;
  bit            m_prio = 1'b0;

  logic [DW-1:0] deq_log[$];
  int            acc_cnt;
  bit            last_ready;

  always #5 Clock = ~Clock;

  sram1d_fifo_ctrl #(.DWidth(DW), .AWidth(AW)) dut (
    .Clock    (Clock),
    .Reset_N  (Reset_N),
    .InData   (InData),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Count    (Count)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against model at negedge, advance model.
  task automatic step(input bit rst_n, input bit v, input logic [DW-1:0] d, input bit ordy);
    bit byp, rw, wok, rdy, vld, enq, deq, wr, rd, confl;
    int cnt;
    Reset_N  = rst_n;
    InValid  = v;
    InData   = d;
    OutReady = ordy;
    @(negedge Clock);
    byp = (m_mem.size() == 0) && !m_infl && (m_out.size() < 2);
    rw  = (m_mem.size() > 0) && ((m_out.size() + int'(m_infl)) < 2);
    wok = !byp && (m_mem.size() < SRAM_WORDS);
    rdy = byp || (wok && (!rw || m_prio));
    vld = m_out.size() > 0;
    cnt = m_mem.size() + int'(m_infl) + m_out.size();
    enq = v && rdy;
    deq = ordy && vld;
    wr  = enq && !byp;
    rd  = rw && !wr;
    confl = rw && v && wok;
    chk("in_ready", DW'(InReady), DW'(rdy));
    chk("out_valid", DW'(OutValid), DW'(vld));
    if (vld) chk("out_data", OutData, m_out[0]);
    chk("count", DW'(Count), DW'(cnt));
    chk("count_cap", DW'(Count <= 4'd6), DW'(1'b1));
    chk("sram_en", DW'(dut.u_sram.Enable), DW'(wr || rd));
    chk("sram_we", DW'(dut.u_sram.Write && dut.u_sram.Enable), DW'(wr));
    last_ready = InReady;
    if (InReady && v) acc_cnt++;
    if (OutValid && ordy) deq_log.push_back(OutData);
    if (!rst_n) begin
      m_out.delete();
      m_mem.delete();
      m_infl = 1'b0;
      m_prio = 1'b0;
    end else begin
      if (deq) void'(m_out.pop_front());
      if (m_infl) m_out.push_back(m_infl_d);
      if (enq && byp) m_out.push_back(d);
      if (wr) m_mem.push_back(d);
      if (rd) begin
        m_infl   = 1'b1;
        m_infl_d = m_mem.pop_front();
      end else begin
        m_infl = 1'b0;
      end
      if (confl) m_prio = !m_prio;
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_out_valid", DW'(OutValid), DW'(1'b0));
    chk("rst_count", DW'(Count), DW'(0));
    chk("rst_in_ready", DW'(InReady), DW'(1'b1));

    // Bypass
    step(1'b1, 1'b1, 64'hA1, 1'b1);
    chk("byp_valid", DW'(OutValid), DW'(1'b1));
    chk("byp_data", OutData, 64'hA1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("byp_count", DW'(Count), DW'(0));

    // Fill to capacity, then drain in order
    acc_cnt = 0;
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b1, DW'(i), 1'b0);
    chk("fill_accepted", DW'(acc_cnt), DW'(6));
    chk("fill_ready_7th", DW'(last_ready), DW'(1'b0));
    chk("fill_count", DW'(Count), DW'(6));
    deq_log.delete();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("drain_n", DW'(deq_log.size()), DW'(6));
    for (int i = 0; i < 6 && i < deq_log.size(); i++) chk("drain_order", deq_log[i], DW'(i + 1));

    // Conflict: SRAM partly filled, enqueue and dequeue both held
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, DW'(16'h100 + i), 1'b0);
    for (int i = 6; i <= 25; i++) step(1'b1, 1'b1, DW'(16'h100 + i), 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("conflict_empty", DW'(Count), DW'(0));

    // Read latency: 2 in buffer, 2 in SRAM; drain buffer then watch SRAM path
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, DW'(i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("lat_t1_valid", DW'(OutValid), DW'(1'b0));
    step(1'b1, 1'b0, '0, 1'b0);
    chk("lat_t2_valid", DW'(OutValid), DW'(1'b1));
    chk("lat_t2_data", OutData, DW'(3));

    // Reset in the cycle after a read is issued
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, DW'(16'h200 + i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rmr_valid", DW'(OutValid), DW'(1'b0));
    chk("rmr_count", DW'(Count), DW'(0));
    chk("rmr_ready", DW'(InReady), DW'(1'b1));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random traffic with pointer wrap
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("rand_empty", DW'(Count), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
